i2c_master_rw: RTL and testbench
================================

I2C_MASTER_RW -- requirements
Module: i2c_master_rw

Interface
REQ-001 Parameter QDIV, default 250: system clocks per SCL quarter-period, legal range >=2.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd  input  2  command code: 0 START, 1 WRITE, 2 READ, 3 STOP.
REQ-007 tx_data  input  8  byte for WRITE, captured on acceptance.
REQ-008 rd_nack  input  1  for READ, captured on acceptance: 0 = master ACKs, 1 = master NACKs.
REQ-009 rx_data  output  8  byte received by the last READ.
REQ-010 done  output  1  one-cycle pulse when a command completes.
REQ-011 ack_err  output  1  last WRITE saw NACK; valid with done.
REQ-012 cmd_err  output  1  last command was illegal in its state; valid with done.
REQ-013 busy  output  1  high from START acceptance until STOP completes.
REQ-014 scl  output  1  push-pull SCL.
REQ-015 sda  inout  1  open-drain: driven 0 or released (high-Z); external pull-up.

Function
REQ-016 Handshake: a command is accepted on a cycle with cmd_valid && cmd_ready; cmd, tx_data and rd_nack are latched then.
REQ-017 cmd_ready is 1 only in IDLE and HOLD, and 0 in every other state and during the cycle done pulses.
REQ-018 States are IDLE, RS_A, RS_B, ST_A, ST_B, BIT, HOLD, SP_A, SP_B, ERR.
- Each phase state lasts 2*QDIV clocks.
- BIT lasts 4*QDIV per bit.
REQ-019 IDLE (scl=1, sda released): START goes to ST_A; WRITE, READ or STOP goes to ERR.
REQ-020 ST_A holds sda=0, scl=1, then goes to ST_B.
REQ-021 ST_B holds sda=0, scl=0, then goes to HOLD with done=1.
REQ-022 HOLD holds scl=0, sda unchanged from the prior phase.
- WRITE or READ goes to BIT.
- STOP goes to SP_A.
- START (repeated start) goes to RS_A.
REQ-023 RS_A holds sda released, scl=0; RS_B holds sda released, scl=1; RS_B then goes to ST_A.
REQ-024 SP_A holds sda=0, scl=1; SP_B holds sda released, scl=1.
- SP_B then goes to IDLE with done=1 and busy=0.
REQ-025 BIT quarter phases, per bit:
- Q0: scl=0, sda set up.
- Q1 and Q2: scl=1.
- Q3: scl=0.
- sda is sampled on the last clock of Q1.
REQ-026 A byte is 9 bits, MSB first; bit 9 is the ACK slot.
REQ-027 WRITE drives tx_data bits 7..0, then releases sda in bit 9.
- ack_err = sampled ACK bit.
REQ-028 READ releases sda for bits 1-8 and shifts the samples into rx_data MSB first.
- In bit 9, sda is driven low if rd_nack=0, released if rd_nack=1.
- ack_err=0.
REQ-029 Byte completion: after 36*QDIV clocks in BIT, the block goes to HOLD.
- done pulses on the last BIT clock.
- rx_data updates on that same cycle.
REQ-030 ERR lasts one cycle with no bus activity, asserts done=1 and cmd_err=1, then returns to IDLE.
REQ-031 cmd_err=0 on every legal completion; ack_err and cmd_err hold until the next done.
REQ-032 Counters: the quarter counter is ceil(log2(QDIV)) bits wide and wraps to 0 at QDIV-1; the bit counter is 4 bits, 0..8.
REQ-033 cmd_valid outside the ready states is ignored and is not queued.

Reset
REQ-034 reset asserted at any time, including mid-byte, immediately forces IDLE with:
- scl=1, sda released.
- cmd_ready=1, done=0, busy=0.
- ack_err=0, cmd_err=0, rx_data=0x00.
- all counters cleared.
REQ-035 After reset deassertion, no bus edge occurs until a START is accepted.

Verification (QDIV=4, pull-up on sda)
REQ-036 START from IDLE -> sda falls while scl=1, done pulses 16 clocks after acceptance, busy=1, cmd_ready=1 in HOLD.
REQ-037 WRITE 0xA5, slave ACKs -> sda sequence 1,0,1,0,0,1,0,1 on scl rising edges, done 144 clocks after acceptance, ack_err=0.
REQ-038 WRITE 0x3C, no slave -> ack_err=1 with done; block remains in HOLD.
REQ-039 READ, rd_nack=0, slave drives 0x96 -> rx_data=0x96 at done, master holds sda=0 during bit 9 scl high.
REQ-040 START in HOLD then STOP -> repeated start (sda falls with scl high, no prior stop), then stop (sda rises with scl high), busy=0 after SP_B.
REQ-041 Illegal command and mid-transfer reset:
- WRITE in IDLE -> done and cmd_err=1 one cycle later, scl/sda unchanged.
- reset during bit 4 of a WRITE -> scl=1, sda released, all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/i2c_master_rw.sv
// i2c_master_rw: command-driven I2C master (START/WRITE/READ/STOP) with open-drain sda.
module i2c_master_rw #(
  parameter int QDIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       rd_nack,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       ack_err,
  output logic       cmd_err,
  output logic       busy,
  output logic       scl,
  inout  wire        sda
);
  localparam int QW = $clog2(QDIV);
  typedef enum logic [3:0] {IDLE, RS_A, RS_B, ST_A, ST_B, BIT, HOLD, SP_A, SP_B, ERR} state_t;
  state_t state;
  logic [QW-1:0] q;
  logic [1:0] qi;
  logic [3:0] bc;
  logic [7:0] sh;
  logic is_rd, nack_r, ack_s, sda_lo;
  logic tick, ph_end, timed, accept;
  assign sda = sda_lo ? 1'b0 : 1'bz;
  assign cmd_ready = (state == IDLE || state == HOLD) && !done;
  assign accept = cmd_valid && cmd_ready;
  assign tick = q == QW'(QDIV - 1);
  assign ph_end = tick && qi == 2'd1;
  assign timed = state inside {RS_A, RS_B, ST_A, ST_B, SP_A, SP_B, BIT};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q <= '0;
      qi <= '0;
      bc <= '0;
      sh <= '0;
      is_rd <= 1'b0;
      nack_r <= 1'b0;
      ack_s <= 1'b0;
      sda_lo <= 1'b0;
      scl <= 1'b1;
      rx_data <= '0;
      done <= 1'b0;
      ack_err <= 1'b0;
      cmd_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= 1'b0;
      q <= (timed && !tick) ? q + 1'b1 : '0;
      qi <= !timed ? 2'd0 : (state != BIT && ph_end) ? 2'd0 : qi + {1'b0, tick};
      case (state)
        IDLE: if (accept) begin
          if (cmd == 2'd0) begin
            state <= ST_A;
            sda_lo <= 1'b1;
            busy <= 1'b1;
          end else state <= ERR;
        end
        ERR: begin
          state <= IDLE;
          done <= 1'b1;
          cmd_err <= 1'b1;
          ack_err <= 1'b0;
        end
        ST_A: if (ph_end) begin
          state <= ST_B;
          scl <= 1'b0;
        end
        ST_B: if (ph_end) begin
          state <= HOLD;
          done <= 1'b1;
          cmd_err <= 1'b0;
          ack_err <= 1'b0;
        end
        HOLD: if (accept) begin
          case (cmd)
            2'd0: begin
              state <= RS_A;
              sda_lo <= 1'b0;
            end
            2'd3: begin
              state <= SP_A;
              scl <= 1'b1;
              sda_lo <= 1'b1;
            end
            default: begin
              state <= BIT;
              sh <= tx_data;
              is_rd <= cmd == 2'd2;
              nack_r <= rd_nack;
              bc <= '0;
              sda_lo <= cmd == 2'd1 && !tx_data[7];
            end
          endcase
        end
        RS_A: if (ph_end) begin
          state <= RS_B;
          scl <= 1'b1;
        end
        RS_B: if (ph_end) begin
          state <= ST_A;
          sda_lo <= 1'b1;
        end
        SP_A: if (ph_end) begin
          state <= SP_B;
          sda_lo <= 1'b0;
        end
        SP_B: if (ph_end) begin
          state <= IDLE;
          done <= 1'b1;
          busy <= 1'b0;
          cmd_err <= 1'b0;
          ack_err <= 1'b0;
        end
        BIT: if (tick) begin
          if (qi == 2'd0) scl <= 1'b1;
          if (qi == 2'd1) begin
            if (bc == 4'd8) ack_s <= sda;
            else sh <= {sh[6:0], sda};
          end
          if (qi == 2'd2) scl <= 1'b0;
          // sda for the next bit changes only while scl is low
          if (qi == 2'd3) begin
            if (bc == 4'd8) begin
              state <= HOLD;
              done <= 1'b1;
              cmd_err <= 1'b0;
              ack_err <= !is_rd && ack_s;
              if (is_rd) rx_data <= sh;
            end else begin
              bc <= bc + 1'b1;
              sda_lo <= (bc == 4'd7) ? (is_rd && !nack_r) : (!is_rd && !sh[7]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_rw.sv
// tb_i2c_master_rw: directed bench for i2c_master_rw at QDIV=4 with a cycle-timed slave.
module tb_i2c_master_rw;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] tx_data = 8'h00;
  logic rd_nack = 1'b0;
  logic cmd_ready, done, ack_err, cmd_err, busy, scl;
  logic [7:0] rx_data;
  logic slave_lo = 1'b0;
  wire sda_w;
  pullup (sda_w);
  assign sda_w = slave_lo ? 1'b0 : 1'bz;
  i2c_master_rw #(.QDIV(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .tx_data(tx_data), .rd_nack(rd_nack), .rx_data(rx_data), .done(done), .ack_err(ack_err),
    .cmd_err(cmd_err), .busy(busy), .scl(scl), .sda(sda_w)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int rc = 0, starts = 0, stops = 0, scl_edges = 0, lat = 0;
  logic [8:0] rec = '0;
  always @(posedge scl) begin
    if (rc < 9) rec[8-rc] = sda_w;
    rc++;
  end
  always @(scl) scl_edges++;
  always @(negedge sda_w) if (scl) starts++;
  always @(posedge sda_w) if (scl) stops++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // sl[8-n] set means the slave pulls sda low throughout bit n
  task automatic run(input logic [1:0] c, input logic [7:0] tx, input logic nk,
                     input logic [8:0] sl, input int lim, output int l);
    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    cmd = c; tx_data = tx; rd_nack = nk; cmd_valid = 1'b1; rc = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    l = 0;
    forever begin
      if (l % 16 == 0 && l < 144) slave_lo = sl[8 - l/16];
      if (done || l >= lim) break;
      @(negedge clk);
      l++;
    end
    slave_lo = 1'b0;
    check("ready_low_on_done", cmd_ready, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_scl", scl, 1);
    check("rst_sda", sda_w, 1);
    check("rst_rx", rx_data, 8'h00);
    check("rst_errs", {ack_err, cmd_err}, 2'b00);
    reset = 1'b0;
    scl_edges = 0;
    repeat (5) @(negedge clk);
    check("idle_quiet", scl_edges, 0);
    run(2'd1, 8'h55, 1'b0, 9'h000, 10, lat);
    check("err_lat", lat, 1);
    check("err_cmd_err", cmd_err, 1);
    check("err_bus", {scl, sda_w, busy}, 3'b110);
    check("err_no_start", starts, 0);
    run(2'd0, 8'h00, 1'b0, 9'h000, 40, lat);
    check("start_lat", lat, 16);
    check("start_busy", busy, 1);
    check("start_cmd_err", cmd_err, 0);
    check("start_cond", starts, 1);
    @(negedge clk);
    check("hold_ready", cmd_ready, 1);
    run(2'd1, 8'hA5, 1'b0, 9'h001, 200, lat);
    check("wr_a5_lat", lat, 144);
    check("wr_a5_ack_err", ack_err, 0);
    check("wr_a5_bits", rec, 9'h14A);
    check("wr_a5_edges", rc, 9);
    run(2'd1, 8'h3C, 1'b0, 9'h000, 200, lat);
    check("wr_3c_lat", lat, 144);
    check("wr_3c_ack_err", ack_err, 1);
    check("wr_3c_bits", rec, 9'h079);
    @(negedge clk);
    check("wr_3c_hold", {cmd_ready, busy}, 2'b11);
    run(2'd2, 8'h00, 1'b0, {~8'h96, 1'b0}, 200, lat);
    check("rd_lat", lat, 144);
    check("rd_data", rx_data, 8'h96);
    check("rd_ack_err", ack_err, 0);
    check("rd_bits_master_ack", rec, 9'h12C);
    run(2'd0, 8'h00, 1'b0, 9'h000, 60, lat);
    check("rs_lat", lat, 32);
    check("rs_start_cond", starts, 2);
    check("rs_no_stop", stops, 0);
    run(2'd3, 8'h00, 1'b0, 9'h000, 40, lat);
    check("sp_lat", lat, 16);
    check("sp_stop_cond", stops, 1);
    check("sp_busy", busy, 0);
    check("sp_bus", {scl, sda_w}, 2'b11);
    run(2'd0, 8'h00, 1'b0, 9'h000, 40, lat);
    check("start2_lat", lat, 16);
    @(negedge clk);
    cmd = 2'd1; tx_data = 8'h00; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (56) @(negedge clk);
    check("mid_byte_scl_high", scl, 1);
    check("mid_byte_sda_low", sda_w, 0);
    reset = 1'b1;
    #1;
    check("arst_scl_sda", {scl, sda_w}, 2'b11);
    check("arst_ctrl", {cmd_ready, done, busy}, 3'b100);
    check("arst_errs", {ack_err, cmd_err}, 2'b00);
    check("arst_rx", rx_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    scl_edges = 0;
    repeat (20) @(negedge clk);
    check("post_rst_quiet", scl_edges, 0);
    check("post_rst_ready", cmd_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
